// File: rtl/acc_drain_pkg.sv
// Shared types and constants for the accumulator drain block.
package acc_drain_pkg;

  // Width of the requantization shift amount.
  localparam int SHIFT_W = 5;

  // Drain controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } drain_state_e;

endpackage

// File: rtl/acc_drain_if.sv
// Output element stream of the drain block.
// Handshake: a beat transfers on a rising edge where outValid and outReady
// are both high; while outValid is high and outReady low, the master holds
// outData/outRow/outCol/outLast stable, and outValid never drops without a
// transfer except on reset.
interface acc_drain_if #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int dataSize = 16
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                outValid;
  logic                outReady;
  logic [dataSize-1:0] outData;
  logic [RW-1:0]       outRow;
  logic [CW-1:0]       outCol;
  logic                outLast;

  modport master (
    output outValid, outData, outRow, outCol, outLast,
    input  outReady
  );

  modport slave (
    input  outValid, outData, outRow, outCol, outLast,
    output outReady
  );
endinterface

// File: rtl/acc_drain_requant.sv
// Saturating arithmetic right shift of a signed accumulator into an
// unsigned-range output element: negatives clamp to 0, large values clamp
// to the largest positive dataSize-bit signed value.
module acc_requant
  import acc_drain_pkg::*;
#(
  parameter int accSize  = 32,
  parameter int dataSize = 16
) (
  input  logic signed [accSize-1:0] acc,
  input  logic [SHIFT_W-1:0]        shift,
  output logic [dataSize-1:0]       sat
);
  localparam int MAX_I = (1 << (dataSize - 1)) - 1;
  localparam logic signed [accSize-1:0] MAX_S = accSize'(MAX_I);

  logic signed [accSize-1:0] shifted;

  // Shift, then clamp into [0, 2^(dataSize-1)-1].
  always_comb begin
    shifted = acc >>> shift;
    if (shifted < 0) begin
      sat = '0;
    end else if (shifted > MAX_S) begin
      sat = dataSize'(MAX_I);
    end else begin
      sat = shifted[dataSize-1:0];
    end
  end
endmodule

// File: rtl/acc_drain.sv
// Drains a ROWS x COLS PE accumulator array: snapshots all accumulators on
// start, pulses the PE clear, then streams requantized elements in
// row-major order over a valid/ready interface.
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int accSize  = 32,
  parameter int dataSize = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [SHIFT_W-1:0]           shiftAmt,
  input  logic [ROWS*COLS*accSize-1:0] accIn,
  acc_drain_if.master                  out_if,
  output logic                         clearPe,
  output logic                         busy,
  output logic                         done,
  output drain_state_e                 dbg_state
);
  localparam int N  = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  drain_state_e       state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               clear_q, clear_d;

  // Snapshot buffer carries no reset; it is always written before use.
  logic [accSize-1:0] snap_q [N];

  logic               accept;
  logic               is_last;
  logic [accSize-1:0] sel_word;
  logic [dataSize-1:0] rq_data;

  assign accept  = (state_q == IDLE) && start;
  assign is_last = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));

  // Next-state logic: start only in IDLE, advance on each handshake,
  // leave the index parked on the last element when moving to DONE.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    shift_d = shift_q;
    clear_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          row_d   = '0;
          col_d   = '0;
          shift_d = shiftAmt;
          clear_d = 1'b1;
        end
      end
      SEND: begin
        if (out_if.outReady) begin
          if (is_last) begin
            state_d = DONE;
          end else if (col_q == CW'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; reset aborts any drain immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      shift_q <= '0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      shift_q <= shift_d;
      clear_q <= clear_d;
    end
  end

  // Capture every accumulator on an accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        snap_q[i] <= accIn[i*accSize +: accSize];
      end
    end
  end

  // Select the snapshot word addressed by the current row/column.
  always_comb begin
    sel_word = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((row_q == RW'(r)) && (col_q == CW'(c))) begin
          sel_word = snap_q[r*COLS + c];
        end
      end
    end
  end

  acc_requant #(
    .accSize  (accSize),
    .dataSize (dataSize)
  ) u_requant (
    .acc   (sel_word),
    .shift (shift_q),
    .sat   (rq_data)
  );

  assign out_if.outValid = (state_q == SEND);
  assign out_if.outData  = (state_q == SEND) ? rq_data : '0;
  assign out_if.outRow   = row_q;
  assign out_if.outCol   = col_q;
  assign out_if.outLast  = (state_q == SEND) && is_last;
  assign clearPe         = clear_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain: scoreboard of expected beats filled at
// start, compared on every presented beat.
module tb_acc_drain;
  import acc_drain_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int AW   = 32;
  localparam int DW   = 16;
  localparam int N    = ROWS * COLS;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic               start = 1'b0;
  logic [SHIFT_W-1:0] shift_amt = '0;
  logic [N*AW-1:0]    acc_in = '0;
  logic               clear_pe, busy, done;
  drain_state_e       dbg_state;

  acc_drain_if #(.ROWS(ROWS), .COLS(COLS), .dataSize(DW)) bus ();

  acc_drain #(
    .ROWS(ROWS), .COLS(COLS), .accSize(AW), .dataSize(DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .shiftAmt  (shift_amt),
    .accIn     (acc_in),
    .out_if    (bus.master),
    .clearPe   (clear_pe),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // scoreboard: {last, row[1:0], col[1:0], data[15:0]}
  logic [20:0] exp_q[$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference requantization: saturating shift, clamp to [0, 32767].
  function automatic logic [DW-1:0] rq(input logic [31:0] a, input int sh);
    logic [31:0] v;
    if (a[31]) return '0;
    v = a >> sh;
    if (v > 32'd32767) return 16'd32767;
    return v[DW-1:0];
  endfunction

  task automatic set_acc(input int i, input logic [31:0] v);
    acc_in[i*AW +: AW] = v;
  endtask

  // Push expectations from the current accIn, then pulse start.
  task automatic start_drain(input logic [SHIFT_W-1:0] sh, input bit scramble);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back({(i == N - 1), 2'(i / COLS), 2'(i % COLS), rq(acc_in[i*AW +: AW], int'(sh))});
    end
    shift_amt = sh;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      for (int i = 0; i < N; i++) set_acc(i, $urandom);
    end
  endtask

  // Consume beats from the negedge of the first SEND cycle.
  task automatic drain(input string tg, input int stall_beat, input int stall_len,
                       input int restart_beat, input int abort_beat, input bit start_in_done);
    int beats = 0;
    int cyc = 0;
    int stalls = 0;
    bit fin = 0;
    logic [20:0] e;
    bit rdy;
    while (!fin && cyc < 200) begin
      check({tg, ".clear"}, 32'(clear_pe), (cyc == 0) ? 32'd1 : 32'd0);
      check({tg, ".valid"}, 32'(bus.outValid), 32'd1);
      if (beats == abort_beat) begin
        reset = 1'b1;
        #1;
        check({tg, ".abort_valid"}, 32'(bus.outValid), 32'd0);
        check({tg, ".abort_busy"}, 32'(busy), 32'd0);
        check({tg, ".abort_done"}, 32'(done), 32'd0);
        exp_q.delete();
        bus.outReady = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (exp_q.size() == 0) begin
        check({tg, ".extra_beat"}, 32'(bus.outValid), 32'd0);
        return;
      end
      e = exp_q[0];
      check({tg, ".data"}, 32'(bus.outData), 32'(e[15:0]));
      check({tg, ".row"}, 32'(bus.outRow), 32'(e[19:18]));
      check({tg, ".col"}, 32'(bus.outCol), 32'(e[17:16]));
      check({tg, ".last"}, 32'(bus.outLast), 32'(e[20]));
      rdy = !(beats == stall_beat && stalls < stall_len);
      if (!rdy) stalls++;
      bus.outReady = rdy;
      start = (beats == restart_beat);
      if (rdy) begin
        void'(exp_q.pop_front());
        beats++;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (beats == N) fin = 1;
    end
    check({tg, ".finished"}, 32'(fin), 32'd1);
    check({tg, ".cycles"}, 32'(cyc), 32'(N + stall_len));
    check({tg, ".done"}, 32'(done), 32'd1);
    check({tg, ".done_valid"}, 32'(bus.outValid), 32'd0);
    check({tg, ".done_busy"}, 32'(busy), 32'd1);
    bus.outReady = 1'b0;
    start = start_in_done;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tg, ".idle_busy"}, 32'(busy), 32'd0);
    check({tg, ".idle_done"}, 32'(done), 32'd0);
    check({tg, ".idle_clear"}, 32'(clear_pe), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tg, ".stay_idle"}, 32'(busy), 32'd0);
    check({tg, ".sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.outReady = 1'b0;
    // reset state
    repeat (2) @(negedge clk);
    check("rst.valid", 32'(bus.outValid), 32'd0);
    check("rst.clear", 32'(clear_pe), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.row", 32'(bus.outRow), 32'd0);
    check("rst.col", 32'(bus.outCol), 32'd0);
    check("rst.last", 32'(bus.outLast), 32'd0);
    check("rst.data", 32'(bus.outData), 32'd0);
    check("rst.state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);

    // basic drain: element i = 1000*i, no shift
    for (int i = 0; i < N; i++) set_acc(i, 32'(1000 * i));
    start_drain(5'd0, 1'b0);
    drain("basic", -1, 0, -1, -1, 1'b0);

    // saturation with a 3-cycle stall on beat 3
    for (int i = 0; i < N; i++) set_acc(i, $urandom);
    set_acc(0, 32'h0001_0000);
    set_acc(1, 32'hFFFF_FFF0);
    set_acc(2, 32'h7FFF_FFFF);
    set_acc(3, 32'h8000_0000);
    start_drain(5'd0, 1'b0);
    drain("stall", 2, 3, -1, -1, 1'b0);

    // shift by 2, start re-pulsed in SEND and DONE, accIn scrambled
    for (int i = 0; i < N; i++) set_acc(i, 32'($urandom_range(0, 200000)));
    set_acc(5, 32'd400);
    start_drain(5'd2, 1'b1);
    drain("ignore", -1, 0, 4, -1, 1'b1);

    // shift by 8, reset during beat 5
    for (int i = 0; i < N; i++) set_acc(i, $urandom);
    set_acc(0, 32'h0010_0000);
    start_drain(5'd8, 1'b0);
    drain("abort", -1, 0, -1, 4, 1'b0);
    check("abort.state", 32'(dbg_state), 32'(IDLE));

    // restart after abort with fresh data
    for (int i = 0; i < N; i++) set_acc(i, 32'($urandom_range(0, 30000)));
    set_acc(0, 32'h0010_0000);
    start_drain(5'd8, 1'b0);
    drain("restart", -1, 0, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
